// File: rtl/pc_sequencer_if.sv
// Bus/strobe bundle between the PC sequencer and its surroundings: memory read
// handshake, instruction bus, ALU flags, and the PC/LR bit-slice control strobes.
interface pc_sequencer_if #(
   parameter int WIDTH = 16
) ();
   logic [WIDTH-1:0] SysBus;
   logic             MemReady;
   logic             FlagZ;
   logic             FlagN;
   logic             MemRead;
   logic             IrWe;
   logic [WIDTH-1:0] Ir;
   logic             PcEn;
   logic             PcWe;
   logic             PcSel;
   logic             PcIncCin;
   logic             LrEn;
   logic             LrWe;
   logic             LrSel;
   logic             AluToBus;
   logic             Halted;

   // Sequencer side
   modport master (
      input  SysBus, MemReady, FlagZ, FlagN,
      output MemRead, IrWe, Ir, PcEn, PcWe, PcSel, PcIncCin,
             LrEn, LrWe, LrSel, AluToBus, Halted
   );

   // Memory / datapath side
   modport slave (
      output SysBus, MemReady, FlagZ, FlagN,
      input  MemRead, IrWe, Ir, PcEn, PcWe, PcSel, PcIncCin,
             LrEn, LrWe, LrSel, AluToBus, Halted
   );
endinterface

// File: rtl/pc_sequencer.sv
// Control FSM feeding the PC/LR bit-slice block. Each instruction runs
// fetch -> decode -> PC increment -> optional branch / call / return.
// Holds the instruction register and the memory read handshake.
module pc_sequencer #(
   parameter int WIDTH   = 16,
   parameter int OPC_MSB = 15
) (
   input  logic               Clock,
   input  logic               nReset,
   pc_sequencer_if.master     bus
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_INC    = 3'd3;
   localparam logic [2:0] ST_BRANCH = 3'd4;
   localparam logic [2:0] ST_LINK   = 3'd5;
   localparam logic [2:0] ST_RET    = 3'd6;
   localparam logic [2:0] ST_HALT   = 3'd7;

   localparam logic [3:0] OP_BR   = 4'b1000;
   localparam logic [3:0] OP_BZ   = 4'b1001;
   localparam logic [3:0] OP_BN   = 4'b1010;
   localparam logic [3:0] OP_CALL = 4'b1100;
   localparam logic [3:0] OP_RET  = 4'b1101;
   localparam logic [3:0] OP_HLT  = 4'b1111;

   logic [2:0]       state;
   logic [2:0]       nextState;
   logic [WIDTH-1:0] irReg;
   logic             flagZReg;
   logic             flagNReg;
   logic [3:0]       opcode;
   logic             irWe;

   assign opcode = irReg[OPC_MSB -: 4];
   // Fetch completes in the same cycle memory signals ready.
   assign irWe   = (state == ST_FETCH) && bus.MemReady;

   // State register; reset drops straight to IDLE so no write strobe survives it
   always_ff @(posedge Clock or negedge nReset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!nReset) state <= ST_IDLE;
      else         state <= nextState;
   end

   // Instruction register loads only on an accepted fetch
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset)   irReg <= '0;
      else if (irWe) irReg <= bus.SysBus;
   end

   // Flags are captured once, in DECODE, and steer the INC decision
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         flagZReg <= 1'b0;
         flagNReg <= 1'b0;
      end else if (state == ST_DECODE) begin
         flagZReg <= bus.FlagZ;
         flagNReg <= bus.FlagN;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      nextState = state;
      case (state)
         ST_IDLE:   nextState = ST_FETCH;
         ST_FETCH:  if (bus.MemReady) nextState = ST_DECODE;
         ST_DECODE: nextState = ST_INC;
         ST_INC: begin
            case (opcode)
               OP_BR:   nextState = ST_BRANCH;
               OP_BZ:   nextState = flagZReg ? ST_BRANCH : ST_FETCH;
               OP_BN:   nextState = flagNReg ? ST_BRANCH : ST_FETCH;
               OP_CALL: nextState = ST_LINK;
               OP_RET:  nextState = ST_RET;
               OP_HLT:  nextState = ST_HALT;
               default: nextState = ST_FETCH;
            endcase
         end
         ST_LINK:   nextState = ST_BRANCH;
         ST_BRANCH: nextState = ST_FETCH;
         ST_RET:    nextState = ST_FETCH;
         ST_HALT:   nextState = ST_HALT;
      endcase
   end

   // Moore strobe decode; at most one bus driver per state, PcWe/LrWe disjoint
   always_comb begin
      bus.MemRead  = 1'b0;
      bus.PcEn     = 1'b0;
      bus.PcWe     = 1'b0;
      bus.PcSel    = 1'b0;
      bus.PcIncCin = 1'b0;
      bus.LrEn     = 1'b0;
      bus.LrWe     = 1'b0;
      bus.LrSel    = 1'b0;
      bus.AluToBus = 1'b0;
      bus.Halted   = 1'b0;
      case (state)
         ST_FETCH: begin
            bus.PcEn    = 1'b1;
            bus.MemRead = 1'b1;
         end
         ST_INC: begin
            bus.PcWe     = 1'b1;
            bus.PcIncCin = 1'b1;
         end
         ST_LINK: begin
            bus.LrWe  = 1'b1;
            bus.LrSel = 1'b1;
         end
         ST_BRANCH: begin
            bus.AluToBus = 1'b1;
            bus.PcWe     = 1'b1;
            bus.PcSel    = 1'b1;
         end
         ST_RET: begin
            bus.LrEn  = 1'b1;
            bus.PcWe  = 1'b1;
            bus.PcSel = 1'b1;
         end
         ST_HALT: bus.Halted = 1'b1;
         default: ;
      endcase
   end

   assign bus.IrWe = irWe;
   assign bus.Ir   = irReg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. The reference model expands each
// instruction into its expected per-cycle strobe sequence from the opcode,
// the flags presented during decode and the number of memory wait cycles.
module tb_pc_sequencer;

   logic Clock;
   logic nReset;
   int   checks;
   int   failures;

   pc_sequencer_if #(.WIDTH(16)) bus ();

   pc_sequencer #(.WIDTH(16), .OPC_MSB(15)) dut (
      .Clock  (Clock),
      .nReset (nReset),
      .bus    (bus)
   );

   // Strobe word: {MemRead,IrWe,PcEn,PcWe,PcSel,PcIncCin,LrEn,LrWe,LrSel,AluToBus,Halted}
   localparam logic [10:0] B_MEMREAD = 11'b100_0000_0000;
   localparam logic [10:0] B_IRWE    = 11'b010_0000_0000;
   localparam logic [10:0] B_PCEN    = 11'b001_0000_0000;
   localparam logic [10:0] B_PCWE    = 11'b000_1000_0000;
   localparam logic [10:0] B_PCSEL   = 11'b000_0100_0000;
   localparam logic [10:0] B_PCINC   = 11'b000_0010_0000;
   localparam logic [10:0] B_LREN    = 11'b000_0001_0000;
   localparam logic [10:0] B_LRWE    = 11'b000_0000_1000;
   localparam logic [10:0] B_LRSEL   = 11'b000_0000_0100;
   localparam logic [10:0] B_ALU     = 11'b000_0000_0010;
   localparam logic [10:0] B_HALTED  = 11'b000_0000_0001;

   localparam logic [10:0] V_IDLE   = 11'b0;
   localparam logic [10:0] V_FETCH  = B_MEMREAD | B_PCEN;
   localparam logic [10:0] V_ACCEPT = B_MEMREAD | B_PCEN | B_IRWE;
   localparam logic [10:0] V_INC    = B_PCWE | B_PCINC;
   localparam logic [10:0] V_BRANCH = B_ALU | B_PCWE | B_PCSEL;
   localparam logic [10:0] V_LINK   = B_LRWE | B_LRSEL;
   localparam logic [10:0] V_RET    = B_LREN | B_PCWE | B_PCSEL;
   localparam logic [10:0] V_HALT   = B_HALTED;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [10:0] ctlNow();
      return {bus.MemRead, bus.IrWe, bus.PcEn, bus.PcWe, bus.PcSel, bus.PcIncCin,
              bus.LrEn, bus.LrWe, bus.LrSel, bus.AluToBus, bus.Halted};
   endfunction

   task automatic drive(input logic mr, input logic [15:0] sb, input logic z, input logic n);
      bus.MemReady = mr;
      bus.SysBus   = sb;
      bus.FlagZ    = z;
      bus.FlagN    = n;
      #1;
   endtask

   task automatic tick();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   // Bus-driver exclusivity and PcWe/LrWe exclusivity, checked every cycle
   always @(negedge Clock) begin
      #2;
      checks++;
      if (($countones({bus.PcEn, bus.LrEn, bus.AluToBus}) > 1) || (bus.PcWe && bus.LrWe)) begin
         failures++;
         $display("FAIL exclusivity t=%0t ctl=%b required at most one driver and not PcWe&LrWe",
                  $time, ctlNow());
      end
   end

   // Runs one instruction starting in a FETCH cycle and checks every cycle
   // against the sequence implied by the opcode rules.
   task automatic run_instr(input logic [15:0] instr, input int waits,
                            input logic zf, input logic nf, input string name);
      logic [10:0] expSeq[$];
      logic [3:0]  op;
      logic        taken;
      op    = instr[15:12];
      taken = (op == 4'b1000) || (op == 4'b1001 && zf) || (op == 4'b1010 && nf);
      expSeq = {};
      if (taken)              expSeq.push_back(V_BRANCH);
      else if (op == 4'b1100) begin expSeq.push_back(V_LINK); expSeq.push_back(V_BRANCH); end
      else if (op == 4'b1101) expSeq.push_back(V_RET);
      else if (op == 4'b1111) expSeq.push_back(V_HALT);

      for (int w = 0; w < waits; w++) begin
         drive(1'b0, 16'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (ctlNow() !== V_FETCH) begin
            failures++;
            $display("FAIL %s wait%0d ctl=%b required %b", name, w, ctlNow(), V_FETCH);
         end
         tick();
      end

      drive(1'b1, instr, 1'($urandom), 1'($urandom));
      checks++;
      if (ctlNow() !== V_ACCEPT) begin
         failures++;
         $display("FAIL %s accept ctl=%b required %b", name, ctlNow(), V_ACCEPT);
      end
      tick();

      drive(1'($urandom), 16'($urandom), zf, nf);
      checks++;
      if (ctlNow() !== V_IDLE || bus.Ir !== instr) begin
         failures++;
         $display("FAIL %s decode ctl=%b Ir=%h required %b Ir=%h", name, ctlNow(), bus.Ir, V_IDLE, instr);
      end
      tick();

      // Flags flipped after decode must not alter the outcome
      drive(1'($urandom), 16'($urandom), ~zf, ~nf);
      checks++;
      if (ctlNow() !== V_INC || bus.Ir !== instr) begin
         failures++;
         $display("FAIL %s inc ctl=%b Ir=%h required %b Ir=%h", name, ctlNow(), bus.Ir, V_INC, instr);
      end
      tick();

      foreach (expSeq[i]) begin
         drive(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (ctlNow() !== expSeq[i]) begin
            failures++;
            $display("FAIL %s flow%0d ctl=%b required %b", name, i, ctlNow(), expSeq[i]);
         end
         if (expSeq[i] != V_HALT) tick();
      end

      if (op != 4'b1111) begin
         drive(1'b0, 16'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (ctlNow() !== V_FETCH) begin
            failures++;
            $display("FAIL %s refetch ctl=%b required %b", name, ctlNow(), V_FETCH);
         end
      end
   endtask

   task automatic test_reset();
      nReset = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      repeat (2) begin
         tick();
         checks++;
         if (ctlNow() !== V_IDLE || bus.Ir !== 16'h0) begin
            failures++;
            $display("FAIL reset_hold ctl=%b Ir=%h required all zero", ctlNow(), bus.Ir);
         end
      end
      nReset = 1'b1;
      #1;
      checks++;
      if (ctlNow() !== V_IDLE) begin
         failures++;
         $display("FAIL reset_idle ctl=%b required %b", ctlNow(), V_IDLE);
      end
      tick();
      checks++;
      if (ctlNow() !== V_FETCH) begin
         failures++;
         $display("FAIL reset_fetch ctl=%b required %b", ctlNow(), V_FETCH);
      end
   endtask

   task automatic test_wait_fetch();
      run_instr(16'h0123, 3, 1'b0, 1'b0, "wait_fetch");
      tick();
   endtask

   task automatic test_cond_branch();
      run_instr(16'h9000, 0, 1'b1, 1'b0, "bz_taken");    tick();
      run_instr(16'h9000, 1, 1'b0, 1'b1, "bz_untaken");  tick();
      run_instr(16'hA000, 0, 1'b0, 1'b1, "bn_taken");    tick();
      run_instr(16'hA000, 2, 1'b1, 1'b0, "bn_untaken");  tick();
      run_instr(16'h8abc, 0, 1'b0, 1'b0, "br_always");   tick();
   endtask

   task automatic test_call_ret();
      run_instr(16'hC000, 1, 1'b0, 1'b0, "call"); tick();
      run_instr(16'hD000, 0, 1'b1, 1'b1, "ret");  tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         logic [15:0] instr;
         instr = {4'($urandom_range(0, 14)), 12'($urandom)};
         run_instr(instr, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), "random");
         tick();
      end
   endtask

   task automatic test_mid_reset();
      drive(1'b1, 16'hC123, 1'b0, 1'b0); tick();   // accept
      drive(1'b0, 16'h0, 1'b0, 1'b0);    tick();   // decode
      tick();                                      // inc
      checks++;
      if (ctlNow() !== V_LINK) begin
         failures++;
         $display("FAIL midrst_link ctl=%b required %b", ctlNow(), V_LINK);
      end
      #2 nReset = 1'b0;
      #1;
      checks++;
      if (ctlNow() !== V_IDLE || bus.Ir !== 16'h0) begin
         failures++;
         $display("FAIL midrst_async ctl=%b Ir=%h required all zero", ctlNow(), bus.Ir);
      end
      @(negedge Clock);
      nReset = 1'b1;
      #1;
      tick();
      checks++;
      if (ctlNow() !== V_FETCH) begin
         failures++;
         $display("FAIL midrst_resume ctl=%b required %b", ctlNow(), V_FETCH);
      end
   endtask

   task automatic test_halt();
      run_instr(16'hF000, 0, 1'b0, 1'b0, "halt");
      for (int c = 0; c < 10; c++) begin
         tick();
         drive(c[0], 16'($urandom), 1'($urandom), 1'($urandom));
         checks++;
         if (ctlNow() !== V_HALT) begin
            failures++;
            $display("FAIL halt_hold%0d ctl=%b required %b", c, ctlNow(), V_HALT);
         end
      end
      tick();
      nReset = 1'b0;
      #1;
      checks++;
      if (ctlNow() !== V_IDLE) begin
         failures++;
         $display("FAIL halt_reset ctl=%b required %b", ctlNow(), V_IDLE);
      end
      tick();
      nReset = 1'b1;
      bus.MemReady = 1'b0;
      tick();
      checks++;
      if (ctlNow() !== V_FETCH) begin
         failures++;
         $display("FAIL halt_resume ctl=%b required %b", ctlNow(), V_FETCH);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_wait_fetch();
      test_cond_branch();
      test_call_ret();
      test_random();
      test_mid_reset();
      test_halt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
